pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 13 +
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared CPU pipeline-control definitions: hazard FSM encoding and defaults.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hazState_t;

  localparam int TIMEOUT_DEFAULT = 15;
  localparam int REG_W           = 5;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard detection between the ID instruction and the load in EX.
module load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_UseRs,
  input  logic             ID_UseRt,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_WriteAddr,
  output logic             loadUse
);

  logic rsHit;
  logic rtHit;

  assign rsHit = ID_UseRs & (ID_Rs == EX_WriteAddr);
  assign rtHit = ID_UseRt & (ID_Rt == EX_WriteAddr);

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign loadUse = EX_MemRead & (EX_WriteAddr != '0) & (rsHit | rtHit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze with timeout, branch/jump flush, load-use stall.
//   state    | meaning
//   RUN      | normal flow, no outstanding slow memory access
//   MEM_WAIT | data memory access pending, pipeline frozen until Mem_Ready
//   ERROR    | access timed out, pipeline frozen until reset
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_UseRs,
  input  logic             ID_UseRt,
  input  logic             ID_Jump,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_WriteAddr,
  input  logic             EX_BranchTaken,
  input  logic             MEM_MemRead,
  input  logic             MEM_MemWrite,
  input  logic             Mem_Ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             ID_EX_Hold,
  output logic             EX_MEM_Hold,
  output logic             MEM_WB_Bubble,
  output logic             Mem_Req,
  output logic             Mem_Err,
  output logic [CNT_W-1:0] Stall_Count
);

  hazState_t  state;
  logic [3:0] waitCnt;
  logic       loadUse;
  logic       freeze;
  logic       luStall;

  load_use_detect uLoadUse (
    .ID_Rs        (ID_Rs),
    .ID_Rt        (ID_Rt),
    .ID_UseRs     (ID_UseRs),
    .ID_UseRt     (ID_UseRt),
    .EX_MemRead   (EX_MemRead),
    .EX_WriteAddr (EX_WriteAddr),
    .loadUse      (loadUse)
  );

  assign Mem_Req = (state != ERROR) & (MEM_MemRead | MEM_MemWrite);
  assign Mem_Err = (state == ERROR);
  assign freeze  = (Mem_Req & ~Mem_Ready) | (state == ERROR);
  assign luStall = ~freeze & ~EX_BranchTaken & loadUse;

  // Priority: freeze, then taken branch, then load-use, then jump.
  always_comb begin
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Flush   = 1'b0;
    ID_EX_Hold    = 1'b0;
    EX_MEM_Hold   = 1'b0;
    MEM_WB_Bubble = 1'b0;
    if (freeze) begin
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Hold    = 1'b1;
      EX_MEM_Hold   = 1'b1;
      MEM_WB_Bubble = 1'b1;
    end else if (EX_BranchTaken) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (loadUse) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end else if (ID_Jump) begin
      IF_ID_Flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      waitCnt     <= '0;
      Stall_Count <= '0;
    end else begin
      if ((freeze | luStall) && (Stall_Count != '1))
        Stall_Count <= Stall_Count + CNT_W'(1);
      case (state)
        RUN: begin
          if (Mem_Req & ~Mem_Ready) begin
            state   <= MEM_WAIT;
            waitCnt <= 4'd1;
          end
        end
        MEM_WAIT: begin
          if (Mem_Ready) begin
            state   <= RUN;
            waitCnt <= '0;
          end else if (32'(waitCnt) >= TIMEOUT) begin
            state <= ERROR;
          end else begin
            waitCnt <= waitCnt + 4'd1;
          end
        end
        ERROR:   state <= ERROR;
        default: begin
          state   <= RUN;
          waitCnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed corner cases plus random traffic vs a reference model.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int TO  = 15;
  localparam int CW  = 5;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    ID_Rs, ID_Rt, EX_WriteAddr;
  logic          ID_UseRs, ID_UseRt, ID_Jump, EX_MemRead, EX_BranchTaken;
  logic          MEM_MemRead, MEM_MemWrite, Mem_Ready;
  logic          PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush;
  logic          ID_EX_Hold, EX_MEM_Hold, MEM_WB_Bubble, Mem_Req, Mem_Err;
  logic [CW-1:0] Stall_Count;

  pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
    .ID_Jump(ID_Jump), .EX_MemRead(EX_MemRead), .EX_WriteAddr(EX_WriteAddr),
    .EX_BranchTaken(EX_BranchTaken), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .Mem_Ready(Mem_Ready), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush), .ID_EX_Hold(ID_EX_Hold),
    .EX_MEM_Hold(EX_MEM_Hold), .MEM_WB_Bubble(MEM_WB_Bubble), .Mem_Req(Mem_Req),
    .Mem_Err(Mem_Err), .Stall_Count(Stall_Count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0]    ctl;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t expQ[$];
  exp_t mon;
  int   nChecks = 0;
  int   nFails  = 0;

  // Reference model: frozen-cycle count of the pending access, dead flag, total stalls.
  int waited = 0;
  bit dead   = 1'b0;
  int stalls = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic idleIns();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UseRs = 1'b0; ID_UseRt = 1'b0; ID_Jump = 1'b0;
    EX_MemRead = 1'b0; EX_WriteAddr = 5'd0; EX_BranchTaken = 1'b0;
    MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; Mem_Ready = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push the expected outputs for the inputs now applied, then advance the model one clock.
  task automatic predict();
    bit   req, frz, lu;
    exp_t e;
    req = (MEM_MemRead || MEM_MemWrite) && !dead;
    frz = dead || (req && !Mem_Ready);
    lu  = EX_MemRead && (EX_WriteAddr != 0) &&
          ((ID_UseRs && ID_Rs == EX_WriteAddr) || (ID_UseRt && ID_Rt == EX_WriteAddr));
    if (frz)                 e.ctl = {7'b0000111, req, dead};
    else if (EX_BranchTaken) e.ctl = {7'b1111000, req, 1'b0};
    else if (lu)             e.ctl = {7'b0001000, req, 1'b0};
    else if (ID_Jump)        e.ctl = {7'b1110000, req, 1'b0};
    else                     e.ctl = {7'b1100000, req, 1'b0};
    e.cnt = CW'(stalls);
    expQ.push_back(e);
    if (reset) begin
      waited = 0; dead = 1'b0; stalls = 0;
    end else begin
      if ((frz || (lu && !EX_BranchTaken)) && stalls < SAT) stalls++;
      if (!dead) begin
        if (waited == 0) begin
          if (req && !Mem_Ready) waited = 1;
        end else if (Mem_Ready) begin
          waited = 0;
        end else begin
          waited++;
          if (waited > TO) dead = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    predict();
    tick();
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      mon = expQ.pop_front();
      nChecks++;
      if ({PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, ID_EX_Hold, EX_MEM_Hold,
           MEM_WB_Bubble, Mem_Req, Mem_Err} !== mon.ctl) begin
        nFails++;
        $display("FAIL ctl t=%0t got %b expected %b", $time,
                 {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, ID_EX_Hold, EX_MEM_Hold,
                  MEM_WB_Bubble, Mem_Req, Mem_Err}, mon.ctl);
      end
      nChecks++;
      if (Stall_Count !== mon.cnt) begin
        nFails++;
        $display("FAIL stall_count t=%0t got %0d expected %0d", $time, Stall_Count, mon.cnt);
      end
    end
  end

  int stuck = 0;

  initial begin
    idleIns();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step();
    reset = 1'b0;
    step();

    // Load-use on Rs
    EX_MemRead = 1'b1; EX_WriteAddr = 5'd8; ID_Rs = 5'd8; ID_UseRs = 1'b1;
    predict(); #1;
    chk("lu_pc_write", PC_Write, 0);
    chk("lu_id_ex_flush", ID_EX_Flush, 1);
    chk("lu_cnt_before", Stall_Count, 0);
    tick();
    idleIns();
    predict(); #1;
    chk("lu_cnt_after", Stall_Count, 1);
    chk("lu_one_cycle", PC_Write, 1);
    tick();

    // Load to r0 never stalls
    EX_MemRead = 1'b1; EX_WriteAddr = 5'd0; ID_Rs = 5'd0; ID_UseRs = 1'b1;
    predict(); #1;
    chk("r0_pc_write", PC_Write, 1);
    chk("r0_no_flush", ID_EX_Flush, 0);
    tick();

    // Taken branch overrides load-use
    EX_MemRead = 1'b1; EX_WriteAddr = 5'd8; ID_Rs = 5'd8; ID_UseRs = 1'b1; EX_BranchTaken = 1'b1;
    predict(); #1;
    chk("br_if_id_flush", IF_ID_Flush, 1);
    chk("br_id_ex_flush", ID_EX_Flush, 1);
    chk("br_pc_write", PC_Write, 1);
    tick();
    idleIns();
    predict(); #1;
    chk("br_no_stall_cnt", Stall_Count, 1);
    tick();

    // Memory wait: three slow cycles then ready
    reset = 1'b1; step(); reset = 1'b0;
    MEM_MemRead = 1'b1; Mem_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      predict(); #1;
      chk("mw_frozen", PC_Write, 0);
      tick();
    end
    Mem_Ready = 1'b1;
    predict(); #1;
    chk("mw_released", PC_Write, 1);
    chk("mw_no_bubble", MEM_WB_Bubble, 0);
    tick();
    idleIns();
    predict(); #1;
    chk("mw_cnt", Stall_Count, 3);
    tick();

    // Timeout into ERROR, stall counter saturation, recovery only via reset
    reset = 1'b1; step(); reset = 1'b0;
    MEM_MemRead = 1'b1; Mem_Ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      predict(); #1;
      chk("to_not_yet_err", Mem_Err, 0);
      tick();
    end
    predict(); #1;
    chk("to_err", Mem_Err, 1);
    chk("to_req_off", Mem_Req, 0);
    chk("to_cnt16", Stall_Count, 16);
    tick();
    for (int i = 0; i < 20; i++) begin
      Mem_Ready = 1'($urandom_range(0, 1));
      EX_BranchTaken = 1'($urandom_range(0, 1));
      step();
    end
    predict(); #1;
    chk("err_sticky", Mem_Err, 1);
    chk("cnt_saturated", Stall_Count, SAT);
    tick();
    reset = 1'b1; step(); reset = 1'b0;
    Mem_Ready = 1'b1; EX_BranchTaken = 1'b0;
    predict(); #1;
    chk("err_cleared", Mem_Err, 0);
    chk("err_req_back", Mem_Req, 1);
    chk("err_cnt_cleared", Stall_Count, 0);
    tick();

    // Reset abandons an access five cycles into MEM_WAIT
    Mem_Ready = 1'b0;
    repeat (5) step();
    reset = 1'b1; step(); reset = 1'b0;
    Mem_Ready = 1'b1;
    predict(); #1;
    chk("rst_wait_cnt", Stall_Count, 0);
    chk("rst_wait_pc", PC_Write, 1);
    chk("rst_wait_req", Mem_Req, 1);
    tick();
    Mem_Ready = 1'b0;
    predict(); #1;
    chk("rst_wait_fresh_freeze", PC_Write, 0);
    tick();
    Mem_Ready = 1'b1;
    step();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 79) == 0);
      ID_Rs = 5'($urandom_range(0, 3));
      ID_Rt = 5'($urandom_range(0, 3));
      ID_UseRs = 1'($urandom_range(0, 1));
      ID_UseRt = 1'($urandom_range(0, 1));
      ID_Jump = ($urandom_range(0, 5) == 0);
      EX_MemRead = 1'($urandom_range(0, 1));
      EX_WriteAddr = 5'($urandom_range(0, 3));
      EX_BranchTaken = ($urandom_range(0, 7) == 0);
      if (stuck > 0) begin
        MEM_MemRead = 1'b1; MEM_MemWrite = 1'b0; Mem_Ready = 1'b0;
        stuck--;
      end else begin
        MEM_MemRead = ($urandom_range(0, 5) == 0);
        MEM_MemWrite = ($urandom_range(0, 5) == 0);
        Mem_Ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 149) == 0) stuck = 20;
      end
      step();
    end

    reset = 1'b0;
    idleIns();
    step();
    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
    #1;
    if (expQ.size() > 0) begin
      nChecks++;
      nFails++;
      $display("FAIL drain pending=%0d expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
